// File: rtl/window_serializer_pkg.sv
// Shared constants and types for the window serializer (49-tap PISO replay).
package window_serializer_pkg;

  localparam int unsigned DATA_WIDTH = 14;
  localparam int unsigned DEPTH      = 49;
  localparam int unsigned IDX_W      = $clog2(DEPTH);
  localparam int unsigned OVR_W      = 8;
  localparam int unsigned FLAT_W     = DATA_WIDTH * DEPTH;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/window_serializer_if.sv
// Load/stream bundle between the tap bank, the serializer and its consumer.
interface window_serializer_if;
  import window_serializer_pkg::*;

  logic                  load;
  logic                  load_ready;
  logic [FLAT_W-1:0]     din_flat;
  logic [DATA_WIDTH-1:0] dout;
  logic                  dout_valid;
  logic                  dout_ready;
  logic                  dout_last;
  logic                  busy;
  logic [OVR_W-1:0]      overrun_cnt;

  // Environment side: offers windows and consumes the stream.
  modport master (
    output load, din_flat, dout_ready,
    input  load_ready, dout, dout_valid, dout_last, busy, overrun_cnt
  );

  // Serializer side.
  modport slave (
    input  load, din_flat, dout_ready,
    output load_ready, dout, dout_valid, dout_last, busy, overrun_cnt
  );

endinterface

// File: rtl/window_piso_reg.sv
// Loadable DEPTH x DATA_WIDTH window buffer with an indexed read port.
module window_piso_reg
  import window_serializer_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  capture,
  input  logic [FLAT_W-1:0]     din_flat,
  input  logic [IDX_W-1:0]      idx,
  output logic [DATA_WIDTH-1:0] rd_data_c
);

  logic [DATA_WIDTH-1:0] buf_q [DEPTH];

  // Whole window is captured in one cycle; slice k holds tap k+1.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < int'(DEPTH); k++) buf_q[k] <= '0;
    end else if (capture) begin
      for (int k = 0; k < int'(DEPTH); k++) buf_q[k] <= din_flat[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign rd_data_c = buf_q[idx];

endmodule

// File: rtl/window_serializer.sv
// Window serializer top: replays a captured window oldest tap first over a
// valid/ready stream. Define WINDOW_SERIALIZER_OVERRUN_EN to count dropped loads.
module window_serializer
  import window_serializer_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  window_serializer_if.slave bus
);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             capture_c;
  logic             ready_q, valid_q, last_q, busy_q;
  logic             handshake_c;

  assign handshake_c = valid_q & bus.dout_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ready_q <= (state_d == IDLE);
      valid_q <= (state_d == SHIFT);
      last_q  <= (state_d == SHIFT) && (idx_d == '0);
      busy_q  <= (state_d == SHIFT);
    end
  end

  // Next-state: accept only when load_ready is already advertised.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    capture_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.load && ready_q) begin
          capture_c = 1'b1;
          idx_d     = IDX_W'(DEPTH - 1);
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        if (handshake_c) begin
          if (idx_q == '0) state_d = IDLE;
          else             idx_d   = idx_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  window_piso_reg u_buf (
    .clk       (clk),
    .rst       (rst),
    .capture   (capture_c),
    .din_flat  (bus.din_flat),
    .idx       (idx_q),
    .rd_data_c (bus.dout)
  );

  assign bus.load_ready = ready_q;
  assign bus.dout_valid = valid_q;
  assign bus.dout_last  = last_q;
  assign bus.busy       = busy_q;

`ifdef WINDOW_SERIALIZER_OVERRUN_EN
  logic [OVR_W-1:0] ovr_q;

  // Saturating count of loads presented while a frame is in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovr_q <= '0;
    end else if (bus.load && !ready_q && (ovr_q != '1)) begin
      ovr_q <= ovr_q + 1'b1;
    end
  end

  assign bus.overrun_cnt = ovr_q;
`else
  assign bus.overrun_cnt = '0;
`endif

endmodule

// File: tb/tb_window_serializer.sv
// Directed bench for window_serializer: vector table plus frame, stall,
// reset and overrun sequences.
module tb_window_serializer;
  import window_serializer_pkg::*;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  window_serializer_if bus ();

  window_serializer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        load;
    logic        rdy;
    logic        valid;
    int unsigned dout;
    logic        last;
    logic        lr;
    int          din_base;
  } vec_t;

  vec_t vecs [8];

`ifdef WINDOW_SERIALIZER_OVERRUN_EN
  localparam int unsigned EXP_OVR3   = 3;
  localparam int unsigned EXP_OVR100 = 100;
  localparam int unsigned EXP_OVRSAT = 255;
`else
  localparam int unsigned EXP_OVR3   = 0;
  localparam int unsigned EXP_OVR100 = 0;
  localparam int unsigned EXP_OVRSAT = 0;
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Tap k (1..DEPTH) carries base + k.
  task automatic set_window(input int base);
    for (int k = 0; k < int'(DEPTH); k++)
      bus.din_flat[k*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(base + k + 1);
  endtask

  task automatic drain();
    int n;
    bus.load       = 1'b0;
    bus.dout_ready = 1'b1;
    n = 0;
    while (bus.dout_valid === 1'b1 && n < 100) begin
      tick();
      n++;
    end
    if (bus.dout_valid !== 1'b0) chk("drain_timeout", 32'(bus.dout_valid), 32'd0);
  endtask

  // Full frame with ready held high: tap DEPTH first, base + 1 last.
  task automatic full_frame(input string tag, input int base);
    set_window(base);
    bus.load       = 1'b1;
    bus.dout_ready = 1'b1;
    tick();
    bus.load = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      chk({tag, "_valid"}, 32'(bus.dout_valid), 32'd1);
      chk({tag, "_dout"},  32'(bus.dout), 32'(base + int'(DEPTH) - i));
      chk({tag, "_last"},  32'(bus.dout_last), 32'(i == int'(DEPTH) - 1));
      chk({tag, "_lr"},    32'(bus.load_ready), 32'd0);
      tick();
    end
    chk({tag, "_end_valid"}, 32'(bus.dout_valid), 32'd0);
    chk({tag, "_end_lr"},    32'(bus.load_ready), 32'd1);
    chk({tag, "_end_busy"},  32'(bus.busy), 32'd0);
    chk({tag, "_end_last"},  32'(bus.dout_last), 32'd0);
  endtask

  initial begin
    int exp_v;
    int hs;
    int cyc;

    errors = 0;
    checks = 0;

    //               load rdy valid dout last lr base
    vecs[0] = '{1'b1, 1'b0, 1'b1, 149, 1'b0, 1'b0, 100};
    vecs[1] = '{1'b0, 1'b0, 1'b1, 149, 1'b0, 1'b0, 500};
    vecs[2] = '{1'b0, 1'b1, 1'b1, 148, 1'b0, 1'b0, 500};
    vecs[3] = '{1'b1, 1'b1, 1'b1, 147, 1'b0, 1'b0, 500};
    vecs[4] = '{1'b0, 1'b0, 1'b1, 147, 1'b0, 1'b0, 500};
    vecs[5] = '{1'b1, 1'b0, 1'b1, 147, 1'b0, 1'b0, 500};
    vecs[6] = '{1'b0, 1'b1, 1'b1, 146, 1'b0, 1'b0, 500};
    vecs[7] = '{1'b1, 1'b0, 1'b1, 146, 1'b0, 1'b0, 500};

    rst            = 1'b1;
    bus.load       = 1'b0;
    bus.dout_ready = 1'b0;
    bus.din_flat   = '0;
    tick();
    tick();
    chk("rst_lr",    32'(bus.load_ready), 32'd0);
    chk("rst_valid", 32'(bus.dout_valid), 32'd0);
    chk("rst_last",  32'(bus.dout_last), 32'd0);
    chk("rst_busy",  32'(bus.busy), 32'd0);
    chk("rst_dout",  32'(bus.dout), 32'd0);
    chk("rst_ovr",   32'(bus.overrun_cnt), 32'd0);
    rst = 1'b0;
    tick();
    chk("post_rst_lr", 32'(bus.load_ready), 32'd1);

    full_frame("f1", 0);

    // Stalls, ignored mid-frame loads and a window change after acceptance.
    for (int i = 0; i < 8; i++) begin
      bus.load       = vecs[i].load;
      bus.dout_ready = vecs[i].rdy;
      set_window(vecs[i].din_base);
      tick();
      chk($sformatf("vec%0d_valid", i), 32'(bus.dout_valid), 32'(vecs[i].valid));
      chk($sformatf("vec%0d_dout", i),  32'(bus.dout), vecs[i].dout);
      chk($sformatf("vec%0d_last", i),  32'(bus.dout_last), 32'(vecs[i].last));
      chk($sformatf("vec%0d_lr", i),    32'(bus.load_ready), 32'(vecs[i].lr));
    end
    bus.load       = 1'b0;
    bus.dout_ready = 1'b1;
    for (int v = 145; v >= 101; v--) begin
      tick();
      chk("vtail_dout", 32'(bus.dout), 32'(v));
      chk("vtail_last", 32'(bus.dout_last), 32'(v == 101));
    end
    tick();
    chk("vtail_end_valid", 32'(bus.dout_valid), 32'd0);
    chk("vtail_ovr",       32'(bus.overrun_cnt), EXP_OVR3);

    // Ready toggling 1,0,1,0: every value held until taken, 49 handshakes.
    set_window(0);
    bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
    exp_v = int'(DEPTH);
    hs    = 0;
    cyc   = 0;
    while (bus.dout_valid === 1'b1 && cyc < 200) begin
      bus.dout_ready = (cyc % 2 == 0);
      chk("tog_dout", 32'(bus.dout), 32'(exp_v));
      chk("tog_last", 32'(bus.dout_last), 32'(exp_v == 1));
      if (bus.dout_ready) begin
        hs++;
        exp_v--;
      end
      tick();
      cyc++;
    end
    chk("tog_handshakes", 32'(hs), 32'(DEPTH));
    chk("tog_cycles",     32'(cyc), 32'(2 * DEPTH - 1));
    chk("tog_end_lr",     32'(bus.load_ready), 32'd1);

    // Reset after 20 samples abandons the frame.
    set_window(0);
    bus.load       = 1'b1;
    bus.dout_ready = 1'b1;
    tick();
    bus.load = 1'b0;
    repeat (20) tick();
    chk("mid_dout_before_rst", 32'(bus.dout), 32'd29);
    rst = 1'b1;
    tick();
    chk("mid_rst_valid", 32'(bus.dout_valid), 32'd0);
    chk("mid_rst_busy",  32'(bus.busy), 32'd0);
    chk("mid_rst_last",  32'(bus.dout_last), 32'd0);
    chk("mid_rst_lr",    32'(bus.load_ready), 32'd0);
    chk("mid_rst_dout",  32'(bus.dout), 32'd0);
    rst = 1'b0;
    tick();
    chk("mid_post_lr",    32'(bus.load_ready), 32'd1);
    chk("mid_post_valid", 32'(bus.dout_valid), 32'd0);
    chk("mid_post_ovr",   32'(bus.overrun_cnt), 32'd0);
    full_frame("f2", 200);

    // 300 blocked loads while the consumer stalls.
    set_window(0);
    bus.load       = 1'b1;
    bus.dout_ready = 1'b0;
    tick();
    repeat (100) tick();
    chk("sat_ovr100", 32'(bus.overrun_cnt), EXP_OVR100);
    repeat (200) tick();
    chk("sat_ovr300",  32'(bus.overrun_cnt), EXP_OVRSAT);
    chk("sat_hold",    32'(bus.dout), 32'd49);
    chk("sat_busy",    32'(bus.busy), 32'd1);
    drain();
    chk("sat_after_ovr", 32'(bus.overrun_cnt), EXP_OVRSAT);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/window_serializer.md
# window_serializer

Parallel-in/serial-out counterpart of the 49-tap sample delay line in the detection datapath. It captures a full 49-sample window (14-bit samples) in one cycle and replays it one sample per accepted handshake, oldest sample first, so that downstream logic (DAC replay, UART/debug dump, coefficient readback) sees the samples in their original arrival order. It sits between the tap bank and any stream consumer that cannot take 49 words in parallel.

## Interface
- DATA_WIDTH, 14, sample width in bits
- DEPTH, 49, window length in samples (≥2)
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- load  in  1  request to capture din_flat
- load_ready  out  1  high when a load will be accepted this cycle
- din_flat  in  DATA_WIDTH*DEPTH  window; slice k ([k*DATA_WIDTH +: DATA_WIDTH]) = tap k+1; tap 1 newest, tap DEPTH oldest
- dout  out  DATA_WIDTH  current sample
- dout_valid  out  1  dout holds a valid sample
- dout_ready  in  1  consumer accepts dout this cycle
- dout_last  out  1  dout is the final (newest, tap 1) sample of the window
- busy  out  1  frame in progress (state SHIFT)
- overrun_cnt  out  8  dropped-load count (see Configuration)

## Operation
- States: IDLE, SHIFT. Reset → IDLE.
- IDLE: load_ready=1, dout_valid=0. load=1 → capture all DEPTH slices into internal buffer, index counter := DEPTH-1, go SHIFT.
- SHIFT: load_ready=0, dout_valid=1, dout = buffer[index]. Handshake = dout_valid & dout_ready. On handshake with index>0: index := index-1. On handshake with index==0: go IDLE.
- dout_last = (state==SHIFT) & (index==0).
- Emission order: tap DEPTH, DEPTH-1, …, tap 1; exactly DEPTH handshakes per frame.
- dout, dout_last stable while dout_valid=1 and dout_ready=0 (no change without handshake).
- load while load_ready=0: ignored, buffer untouched, frame continues; counted as overrun if enabled.
- din_flat sampled only on the accepting cycle; later changes have no effect on the frame.
- Index counter width $clog2(DEPTH); never wraps below 0.
- Reset values: load_ready=0 during rst cycle then 1, dout_valid=0, dout_last=0, busy=0, dout=0, buffer=0, index=0, overrun_cnt=0.
- Reset mid-frame: frame abandoned, no further samples, IDLE on next cycle.

## Timing
- Load accepted at edge N → dout_valid=1 with tap DEPTH from cycle after N (1-cycle latency).
- With dout_ready held high: one sample per cycle, frame occupies DEPTH cycles, dout_last in the DEPTH-th.
- After last handshake at edge M: dout_valid=0, load_ready=1 from cycle after M; next load accepted no earlier than that cycle (minimum one idle cycle between frames, frame period ≥ DEPTH+1 cycles).
- load_ready is a pure function of state (no combinational path from load or dout_ready).
- Consumer stalls (dout_ready=0) extend the frame by the stall count; no sample lost or duplicated.

## Configuration
- WINDOW_SERIALIZER_OVERRUN_EN defined: overrun_cnt increments by 1 on every cycle with load=1 & load_ready=0 & ~rst, saturates at 255, cleared only by rst.
- Not defined: counter logic absent, overrun_cnt tied to 0; all other behaviour identical.

## Structure
- Shared package: DATA_WIDTH, DEPTH defaults, derived IDX_W=$clog2(DEPTH), state enum {IDLE, SHIFT}, overrun counter width (8).
- One sub-module: window_piso_reg — loadable DEPTH×DATA_WIDTH buffer with indexed read mux; FSM, index counter, handshake and overrun counter stay in the top.

## Test plan
- Reset, then load with tap k = k (1..49), dout_ready=1 → dout sequence 49,48,…,1 on 49 consecutive cycles, dout_last only with value 1, load_ready returns 1 next cycle.
- Same frame, dout_ready toggling 1,0,1,0 → each value held across stalls, exactly 49 handshakes, no duplicates.
- load pulsed 3 times mid-frame with different din_flat → original frame unchanged; overrun_cnt=3 with macro, 0 without.
- 300 consecutive blocked loads with macro → overrun_cnt saturates at 255.
- Assert rst after 20 samples emitted → dout_valid=0 next cycle, busy=0, new load then emits full frame from tap 49.
- din_flat changed on the cycle after acceptance → emitted values match the captured window, not the new input.
